bus_capture: RTL and testbench
==============================

# bus_capture

Receiving end of the shared two-source tri-state bus. Samples the resolved bus and the two output-enable lines, tracks which source owns the bus, and captures the last word of each completed ownership into a per-source one-entry buffer with a valid/ready handshake. It also flags bus contention, dead-time (turnaround) violations and buffer overruns. It sits on the consumer side of the bus, opposite the output-enable sequencer that drives `oe`.

## Interface
- `WIDTH`, default 8: bus and data width.
- `MIN_DEAD`, default 1: minimum number of all-off (`oe == 2'b00`) cycles required between two different owners. Legal range 1..15.

- `clk`  in  1  single clock, all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `oe`  in  2  enables as driven on the bus. Bit0 = source A, bit1 = source B.
- `bus`  in  WIDTH  resolved bus value.
- `a_data`  out  WIDTH  last word captured from A.
- `a_valid`  out  1  `a_data` holds an unconsumed word.
- `a_ready`  in  1  consumer accepts `a_data`.
- `b_data`, `b_valid`, `b_ready`: same as the A signals, for source B.
- `contention`  out  1  sticky; both enables were seen high.
- `turnaround_err`  out  1  sticky; dead-time violation.
- `overrun`  out  2  sticky per source (bit0 = A); a capture found that buffer full.
- `clear_err`  in  1  clears all sticky flags.

## Operation
- The FSM has states IDLE, OWN_A, OWN_B and CONTEND. It also holds `last_owner` (NONE/A/B) and a saturating `dead_cnt` (4 bits).
- Transitions are decided from the sampled `oe` each cycle:
  - `oe == 2'b11` from any state → CONTEND. Set `contention`. The in-progress ownership is discarded and no capture occurs.
  - CONTEND → IDLE only on `2'b00`. Set `last_owner = NONE`.
  - IDLE, `2'b01` → OWN_A. IDLE, `2'b10` → OWN_B.
  - OWN_A, `2'b00` → IDLE with `last_owner = A`. OWN_B is symmetric.
  - OWN_A, `2'b10` → OWN_B directly. This sets `turnaround_err` and captures A. OWN_B → OWN_A is symmetric.
- In IDLE, `dead_cnt` increments and saturates at 15. It is cleared on every entry to IDLE.
- On IDLE → OWN_X, if `last_owner` is the other source and `dead_cnt < MIN_DEAD`, set `turnaround_err`.
- A returning to A after any gap is never an error. The same holds for B.
- Shadow registers:
  - Every cycle with `oe == 2'b01`, `shadow_a <= bus`.
  - Every cycle with `oe == 2'b10`, `shadow_b <= bus`.
- Capture happens on the edge where the state leaves OWN_X for IDLE or OWN_Y. At that edge, `x_data <= shadow_x` and `x_valid <= 1`.
- Handshake:
  - `x_valid & x_ready` at an edge clears `x_valid`.
  - If a capture lands on the same edge, the new word loads and `x_valid` stays 1. This is not an overrun.
  - A capture while `x_valid = 1` and `x_ready = 0` sets `overrun[x]`. The old word is overwritten and `x_valid` stays 1.
  - `x_data` is stable while `x_valid = 1` and not accepted.
- Sticky flags:
  - A set event and `clear_err` in the same cycle: the set wins.
  - `clear_err` alone clears the flag at the next edge.

## Timing
- Reset values:
  - state IDLE, `last_owner` NONE, `dead_cnt = 15`, so the first ownership after reset is error-free.
  - `shadow_a`, `shadow_b`, `a_data`, `b_data` = 0.
  - `a_valid`, `b_valid`, `contention`, `turnaround_err` = 0; `overrun = 2'b00`.
- Reset asserted mid-ownership drops the ownership without capture. Reset overrides all other inputs that cycle.
- Capture latency: if cycle k is the last cycle with `oe == 2'b01` and cycle k+1 has `oe != 2'b01`:
  - `a_data` equals `bus` from cycle k.
  - `a_valid` is high from cycle k+2.
- A single-cycle ownership is legal and is captured.
- Flag latency: error flags assert one cycle after the offending `oe` sample.
- Outputs are registered and have no combinational input-to-output paths.

## Configuration
- `BUS_CAPTURE_DEADTIME_CHECK_EN`:
  - Defined: `dead_cnt`, the `last_owner` tracking and `turnaround_err` behave as above.
  - Undefined: that logic is omitted and `turnaround_err` is tied to 0. `MIN_DEAD` is ignored. All other behaviour is identical, including captures on direct A↔B handover.

## Test plan
- Reset, then `oe`: 01 (bus=0x3C), 01 (0x5A), 00, 00; `a_ready = 0` → `a_valid` rises 2 cycles after the last 01 with `a_data = 0x5A`. No flags set.
- `MIN_DEAD = 2`: A owns, 1 cycle of 00, then B owns → `turnaround_err = 1`. After `clear_err`, repeat with 2 cycles of 00 → the flag stays 0.
- `oe` 01 → 11 → 00: `contention = 1`, `a_valid` stays 0. Next A ownership with bus=0x11 captures 0x11 with no `turnaround_err`.
- Two A ownerships (0x01, then 0x02) with `a_ready` held 0 → `overrun = 2'b01` and `a_data = 0x02`. Repeat with `a_ready = 1` on the capture edge → no overrun and `a_valid` stays 1.
- Direct handover 01 → 10 → 00 (A=0xAA, B=0xBB) → both buffers valid with 0xAA and 0xBB. `turnaround_err = 1` only if the macro is defined.
- `rst` asserted during OWN_B → all outputs return to reset values and `b_valid` never rises for the aborted ownership.

Source files
------------

// File: rtl/bus_capture.sv
// rtl/bus_capture.sv - consumer side of the two-source tri-state bus: ownership tracking, per-source capture buffers, error flags
// Optional dead-time checking is enabled by defining BUS_CAPTURE_DEADTIME_CHECK_EN.
module bus_capture #(
    parameter int WIDTH    = 8,
    parameter int MIN_DEAD = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       oe,
    input  logic [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic             contention,
    output logic             turnaround_err,
    output logic [1:0]       overrun,
    input  logic             clear_err
);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, CONTEND} state_t;

    state_t           state;
    logic [WIDTH-1:0] shadow_a;
    logic [WIDTH-1:0] shadow_b;
    logic             cap_a;
    logic             cap_b;
    logic             contend_set;
    logic             ovr_a;
    logic             ovr_b;

    always_comb begin
        cap_a       = 1'b0;
        cap_b       = 1'b0;
        contend_set = (oe == 2'b11);
        if (state == OWN_A && (oe == 2'b00 || oe == 2'b10)) cap_a = 1'b1;
        if (state == OWN_B && (oe == 2'b00 || oe == 2'b01)) cap_b = 1'b1;
        ovr_a = cap_a & a_valid & ~a_ready;
        ovr_b = cap_b & b_valid & ~b_ready;
    end

`ifdef BUS_CAPTURE_DEADTIME_CHECK_EN
    typedef enum logic [1:0] {NONE, LAST_A, LAST_B} owner_t;

    owner_t     last_owner;
    logic [3:0] dead_cnt;
    logic       dead_short;
    logic       turn_set;

    // dead_cnt counts idle-state off cycles; the off cycle that ended the
    // previous ownership is the "+1", so the total gap is compared.
    always_comb begin
        dead_short = (({1'b0, dead_cnt} + 5'd1) < 5'(MIN_DEAD));
        turn_set   = 1'b0;
        if (state == OWN_A && oe == 2'b10) turn_set = 1'b1;
        if (state == OWN_B && oe == 2'b01) turn_set = 1'b1;
        if (state == IDLE && oe == 2'b01 && last_owner == LAST_B && dead_short) turn_set = 1'b1;
        if (state == IDLE && oe == 2'b10 && last_owner == LAST_A && dead_short) turn_set = 1'b1;
    end
`else
    assign turnaround_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shadow_a   <= '0;
            shadow_b   <= '0;
            a_data     <= '0;
            b_data     <= '0;
            a_valid    <= 1'b0;
            b_valid    <= 1'b0;
            contention <= 1'b0;
            overrun    <= 2'b00;
`ifdef BUS_CAPTURE_DEADTIME_CHECK_EN
            last_owner     <= NONE;
            dead_cnt       <= 4'd15;
            turnaround_err <= 1'b0;
`endif
        end else begin
            if (oe == 2'b01) shadow_a <= bus;
            if (oe == 2'b10) shadow_b <= bus;

            case (state)
                IDLE: begin
                    if (oe == 2'b01)      state <= OWN_A;
                    else if (oe == 2'b10) state <= OWN_B;
                    else if (oe == 2'b11) state <= CONTEND;
                end
                OWN_A: begin
                    if (oe == 2'b00)      state <= IDLE;
                    else if (oe == 2'b10) state <= OWN_B;
                    else if (oe == 2'b11) state <= CONTEND;
                end
                OWN_B: begin
                    if (oe == 2'b00)      state <= IDLE;
                    else if (oe == 2'b01) state <= OWN_A;
                    else if (oe == 2'b11) state <= CONTEND;
                end
                default: begin
                    if (oe == 2'b00) state <= IDLE;
                end
            endcase

            // A capture on the accept edge reloads the buffer and keeps it valid.
            if (cap_a) begin
                a_data  <= shadow_a;
                a_valid <= 1'b1;
            end else if (a_ready) begin
                a_valid <= 1'b0;
            end
            if (cap_b) begin
                b_data  <= shadow_b;
                b_valid <= 1'b1;
            end else if (b_ready) begin
                b_valid <= 1'b0;
            end

            contention <= contend_set | (contention & ~clear_err);
            overrun[0] <= ovr_a | (overrun[0] & ~clear_err);
            overrun[1] <= ovr_b | (overrun[1] & ~clear_err);

`ifdef BUS_CAPTURE_DEADTIME_CHECK_EN
            turnaround_err <= turn_set | (turnaround_err & ~clear_err);
            if (oe == 2'b00) begin
                if (state == IDLE) begin
                    if (dead_cnt != 4'd15) dead_cnt <= dead_cnt + 4'd1;
                end else begin
                    dead_cnt <= 4'd0;
                    case (state)
                        OWN_A:   last_owner <= LAST_A;
                        OWN_B:   last_owner <= LAST_B;
                        default: last_owner <= NONE;
                    endcase
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_bus_capture.sv
// tb/tb_bus_capture.sv - directed self-checking bench for bus_capture (MIN_DEAD = 2)
module tb_bus_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] oe;
    logic [7:0] bus;
    logic [7:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic [7:0] b_data;
    logic       b_valid;
    logic       b_ready;
    logic       contention;
    logic       turnaround_err;
    logic [1:0] overrun;
    logic       clear_err;

    int checks   = 0;
    int failures = 0;

`ifdef BUS_CAPTURE_DEADTIME_CHECK_EN
    localparam logic TURN_EXP = 1'b1;
`else
    localparam logic TURN_EXP = 1'b0;
`endif

    bus_capture #(.WIDTH(8), .MIN_DEAD(2)) dut (
        .clk(clk), .rst(rst), .oe(oe), .bus(bus),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .contention(contention), .turnaround_err(turnaround_err),
        .overrun(overrun), .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply inputs for one cycle, then sample 1 time unit after the edge.
    task automatic step(input logic [1:0] o, input logic [7:0] b);
        oe  = o;
        bus = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_a_valid"}, a_valid, 0);
        check({tag, "_b_valid"}, b_valid, 0);
        check({tag, "_a_data"}, a_data, 0);
        check({tag, "_b_data"}, b_data, 0);
        check({tag, "_contention"}, contention, 0);
        check({tag, "_turn"}, turnaround_err, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        rst = 1'b1; oe = 2'b00; bus = 8'h00;
        a_ready = 1'b0; b_ready = 1'b0; clear_err = 1'b0;
        step(2'b00, 8'h00);
        step(2'b00, 8'h00);
        rst = 1'b0;
        check_reset_state("reset");

        // Basic A capture, two-cycle latency
        step(2'b01, 8'h3C);
        step(2'b01, 8'h5A);
        check("basic_not_yet_valid", a_valid, 0);
        step(2'b00, 8'h00);
        check("basic_a_valid", a_valid, 1);
        check("basic_a_data", a_data, 8'h5A);
        step(2'b00, 8'h00);
        check("basic_a_held", a_valid, 1);
        check("basic_flags", {contention, turnaround_err, overrun}, 0);
        a_ready = 1'b1;
        step(2'b00, 8'h00);
        check("basic_accept", a_valid, 0);

        // Dead time: 1 off cycle is short for MIN_DEAD=2, 2 off cycles are fine
        b_ready = 1'b1;
        step(2'b01, 8'h10);
        step(2'b00, 8'h00);
        step(2'b10, 8'h20);
        check("dead1_turn", turnaround_err, TURN_EXP);
        step(2'b00, 8'h00);
        check("dead1_b_capture", b_data, 8'h20);
        clear_err = 1'b1;
        step(2'b00, 8'h00);
        clear_err = 1'b0;
        check("dead_clear", turnaround_err, 0);
        step(2'b01, 8'h30);
        step(2'b00, 8'h00);
        step(2'b00, 8'h00);
        step(2'b10, 8'h40);
        check("dead2_no_turn", turnaround_err, 0);
        step(2'b00, 8'h00);
        step(2'b00, 8'h00);
        a_ready = 1'b0; b_ready = 1'b0;
        check("dead_drained", {a_valid, b_valid}, 0);

        // Contention discards the ownership; set beats clear
        step(2'b01, 8'h77);
        clear_err = 1'b1;
        step(2'b11, 8'hFF);
        check("contend_set_wins", contention, 1);
        clear_err = 1'b0;
        step(2'b00, 8'h00);
        check("contend_no_capture", a_valid, 0);
        check("contend_sticky", contention, 1);
        step(2'b01, 8'h11);
        step(2'b00, 8'h00);
        check("post_contend_valid", a_valid, 1);
        check("post_contend_data", a_data, 8'h11);
        check("post_contend_turn", turnaround_err, 0);
        clear_err = 1'b1;
        step(2'b00, 8'h00);
        clear_err = 1'b0;
        check("contend_cleared", contention, 0);
        a_ready = 1'b1;
        step(2'b00, 8'h00);
        a_ready = 1'b0;

        // Overrun, then capture on the accept edge
        step(2'b01, 8'h01);
        step(2'b00, 8'h00);
        step(2'b01, 8'h02);
        step(2'b00, 8'h00);
        check("ovr_flag", overrun, 2'b01);
        check("ovr_data", a_data, 8'h02);
        check("ovr_valid", a_valid, 1);
        clear_err = 1'b1;
        step(2'b00, 8'h00);
        clear_err = 1'b0;
        check("ovr_cleared", overrun, 2'b00);
        step(2'b01, 8'h03);
        a_ready = 1'b1;
        step(2'b00, 8'h00);
        a_ready = 1'b0;
        check("accept_edge_valid", a_valid, 1);
        check("accept_edge_data", a_data, 8'h03);
        check("accept_edge_no_ovr", overrun, 2'b00);
        a_ready = 1'b1;
        step(2'b00, 8'h00);
        a_ready = 1'b0;

        // Direct handover captures both sources
        step(2'b01, 8'hAA);
        step(2'b10, 8'hBB);
        check("handover_a_valid", a_valid, 1);
        check("handover_turn", turnaround_err, TURN_EXP);
        step(2'b00, 8'h00);
        check("handover_a_data", a_data, 8'hAA);
        check("handover_b_valid", b_valid, 1);
        check("handover_b_data", b_data, 8'hBB);

        // Reset during OWN_B aborts the ownership
        step(2'b10, 8'h99);
        step(2'b10, 8'h98);
        rst = 1'b1;
        step(2'b10, 8'h97);
        rst = 1'b0;
        check_reset_state("midreset");
        step(2'b00, 8'h00);
        check("midreset_b_quiet1", b_valid, 0);
        step(2'b00, 8'h00);
        check("midreset_b_quiet2", b_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
